// File: rtl/slot_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : slot_defs
//  Description : Shared definitions for the slot stream unpacker: FSM state
//                encodings and default slot geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package slot_defs;

    // Stream controller state encodings
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // Default geometry: ten 20-bit numbers
    localparam int c_DEF_SLOT_W    = 20;
    localparam int c_DEF_NUM_SLOTS = 10;

endpackage
`default_nettype wire

// File: rtl/slot_idx_counter.sv
`default_nettype none
// ============================================================================
//  Module      : slot_idx_counter
//  Description : Slot index counter that walks 0..NUM_SLOTS-1 forward or
//                NUM_SLOTS-1..0 in reverse, wrapping at either end. Wrap is
//                by explicit compare, so NUM_SLOTS need not be a power of 2.
//  Ports       : clk     - clock (rising edge)
//                resetn  - synchronous active-low reset, index -> 0
//                init    - load first index of a pass (0 fwd, NUM_SLOTS-1 rev)
//                step    - advance one slot in the direction given by rev
//                rev     - direction: 1 = descending
//                index   - current slot index
//                is_last - index is the final slot of a pass for direction rev
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_idx_counter #(
    parameter int IDX_W     = 4,
    parameter int NUM_SLOTS = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             init,
    input  logic             step,
    input  logic             rev,
    output logic [IDX_W-1:0] index,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_SLOTS - 1);

    logic [IDX_W-1:0] r_index;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_index <= '0;
        end else if (init) begin
            r_index <= rev ? c_LAST : '0;
        end else if (step) begin
            if (rev) begin
                r_index <= (r_index == '0) ? c_LAST : r_index - 1'b1;
            end else begin
                r_index <= (r_index == c_LAST) ? '0 : r_index + 1'b1;
            end
        end
    end

    assign index   = r_index;
    assign is_last = rev ? (r_index == '0) : (r_index == c_LAST);

endmodule
`default_nettype wire

// File: rtl/slot_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : slot_stream_unpacker
//  Description : Captures a packed bus of NUM_SLOTS x SLOT_W numbers, exposes
//                them in parallel and streams them one per valid/ready
//                handshake, forward or reverse, single pass or looping.
//  Ports       : clock/resetn        - clock, synchronous active-low reset
//                load/load_data      - capture packed bus (ignored while busy)
//                start               - begin a stream (IDLE only)
//                mode_rev/mode_loop  - direction / looping, sampled on start
//                abort               - end the stream, back to IDLE
//                slots_q             - registered parallel copy of the bus
//                out_valid/out_ready - stream handshake
//                out_data/out_index  - current slot value and index
//                out_last            - current slot ends this pass
//                busy                - streaming in progress
//                done                - one-cycle pulse after a single pass
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_stream_unpacker
    import slot_defs::*;
#(
    parameter  int SLOT_W    = c_DEF_SLOT_W,
    parameter  int NUM_SLOTS = c_DEF_NUM_SLOTS,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        load,
    input  logic [NUM_SLOTS*SLOT_W-1:0] load_data,
    input  logic                        start,
    input  logic                        mode_rev,
    input  logic                        mode_loop,
    input  logic                        abort,
    output logic [NUM_SLOTS*SLOT_W-1:0] slots_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLOT_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int c_VIEW_N = 2 ** IDX_W;

    logic [1:0]                  r_state;
    logic                        r_rev;
    logic                        r_loop;
    logic [NUM_SLOTS*SLOT_W-1:0] r_slots;

    logic                        w_streaming;
    logic                        w_start_acc;
    logic                        w_hs;
    logic                        w_cnt_rev;
    logic [IDX_W-1:0]            w_index;
    logic                        w_is_last;
    logic [SLOT_W-1:0]           w_view [c_VIEW_N];

    assign w_streaming = (r_state == c_ST_STREAM);
    assign w_start_acc = (r_state == c_ST_IDLE) && start;
    assign w_hs        = w_streaming && out_ready;

    // On the start cycle the mode inputs are not yet registered, so the
    // counter must see mode_rev directly to pick the correct first index.
    assign w_cnt_rev = (r_state == c_ST_IDLE) ? mode_rev : r_rev;

    slot_idx_counter #(
        .IDX_W     (IDX_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_idx (
        .clk     (clock),
        .resetn  (resetn),
        .init    (w_start_acc),
        .step    (w_hs && !abort),
        .rev     (w_cnt_rev),
        .index   (w_index),
        .is_last (w_is_last)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_rev   <= 1'b0;
            r_loop  <= 1'b0;
            r_slots <= '0;
        end else begin
            if (load && !w_streaming) begin
                r_slots <= load_data;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_STREAM;
                        r_rev   <= mode_rev;
                        r_loop  <= mode_loop;
                    end
                end
                c_ST_STREAM: begin
                    if (abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_hs && w_is_last && !r_loop) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Index view padded to a power of two so the mux never reads out of range.
    generate
        for (genvar j = 0; j < c_VIEW_N; j++) begin : g_view
            if (j < NUM_SLOTS) begin : g_used
                assign w_view[j] = r_slots[j*SLOT_W +: SLOT_W];
            end else begin : g_pad
                assign w_view[j] = '0;
            end
        end
    endgenerate

    assign slots_q   = r_slots;
    assign out_valid = w_streaming;
    assign out_index = w_index;
    assign out_data  = w_view[w_index];
    // Counter's is_last is meaningful only while streaming.
    assign out_last  = w_streaming && w_is_last;
    assign busy      = w_streaming;
    assign done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
